// File: rtl/bram_pingpong_ctrl.sv
// bram_pingpong_ctrl
// Bank-ownership controller for the chunk BRAM ring between the DDR transfer
// engine and the LBM compute core. DDR fills one bank while LBM works on the
// previously filled bank; roles rotate once both sides report chunk done.
//
// Parameters:
//   ADDR_W     BRAM address width
//   NUM_BANKS  banks in the ring (2..8)
//   BANK_W     bank index width, derived from NUM_BANKS
//
// Ports:
//   m00_axis_aclk      clock
//   m00_axis_areset    asynchronous active-high reset
//   ddr_req/we/addr    DDR side access request
//   ddr_chunk_done     DDR finished its bank (one-cycle pulse)
//   lbm_req/we/addr    LBM side access request
//   lbm_chunk_done     LBM finished its bank (one-cycle pulse)
//   ddr_ready          DDR side may issue requests (decoded from state)
//   lbm_ready          LBM side may issue requests (decoded from state)
//   ddr_bank/lbm_bank  bank owned by each side
//   lbm_start          pulse on the first RUN cycle after a swap
//   bank_wen           per-bank write enable (registered)
//   bank_addr          per-bank address, bank b at [b*ADDR_W +: ADDR_W] (registered)
//   proto_err          sticky protocol-error flag
//   swap_count         completed swaps
//
// Build option: define PINGPONG_STATS_EN to implement the 16-bit swap counter;
// without it swap_count is tied to zero.

module bram_pingpong_ctrl #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned BANK_W   = $clog2(NUM_BANKS)
) (
  input  logic                          m00_axis_aclk,
  input  logic                          m00_axis_areset,
  input  logic                          ddr_req,
  input  logic                          ddr_we,
  input  logic [ADDR_W-1:0]             ddr_addr,
  input  logic                          ddr_chunk_done,
  input  logic                          lbm_req,
  input  logic                          lbm_we,
  input  logic [ADDR_W-1:0]             lbm_addr,
  input  logic                          lbm_chunk_done,
  output logic                          ddr_ready,
  output logic                          lbm_ready,
  output logic [BANK_W-1:0]             ddr_bank,
  output logic [BANK_W-1:0]             lbm_bank,
  output logic                          lbm_start,
  output logic [NUM_BANKS-1:0]          bank_wen,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  output logic                          proto_err,
  output logic [15:0]                   swap_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_FILL     = 3'd0,
    ST_RUN      = 3'd1,
    ST_WAIT_DDR = 3'd2,
    ST_WAIT_LBM = 3'd3,
    ST_SWAP     = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 ddr_acc;
  logic                 lbm_acc;
  logic                 err_evt;
  logic [BANK_W-1:0]    ddr_bank_nxt;
  logic [NUM_BANKS-1:0] ddr_sel;
  logic [NUM_BANKS-1:0] lbm_sel;

  // State register
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; done pulses from a side that is not ready are ignored
  // simply because no state looks at them.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (ddr_chunk_done) state_nxt = ST_SWAP;
      end
      ST_RUN: begin
        case ({ddr_chunk_done, lbm_chunk_done})
          2'b11:   state_nxt = ST_SWAP;
          2'b10:   state_nxt = ST_WAIT_LBM;
          2'b01:   state_nxt = ST_WAIT_DDR;
          default: state_nxt = ST_RUN;
        endcase
      end
      ST_WAIT_LBM: begin
        if (lbm_chunk_done) state_nxt = ST_SWAP;
      end
      ST_WAIT_DDR: begin
        if (ddr_chunk_done) state_nxt = ST_SWAP;
      end
      ST_SWAP: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // Ready decode from state
  always_comb begin
    ddr_ready = 1'b0;
    lbm_ready = 1'b0;
    case (state)
      ST_FILL:     ddr_ready = 1'b1;
      ST_RUN: begin
        ddr_ready = 1'b1;
        lbm_ready = 1'b1;
      end
      ST_WAIT_DDR: ddr_ready = 1'b1;
      ST_WAIT_LBM: lbm_ready = 1'b1;
      default: begin
        ddr_ready = 1'b0;
        lbm_ready = 1'b0;
      end
    endcase
  end

  // Accept/error qualification and per-bank ownership decode
  always_comb begin
    ddr_acc = ddr_req && ddr_ready;
    lbm_acc = lbm_req && lbm_ready;
    err_evt = (ddr_req && !ddr_ready) || (ddr_chunk_done && !ddr_ready) ||
              (lbm_req && !lbm_ready) || (lbm_chunk_done && !lbm_ready);
    ddr_sel = '0;
    lbm_sel = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      ddr_sel[b] = ddr_acc && (ddr_bank == BANK_W'(b));
      lbm_sel[b] = lbm_acc && (lbm_bank == BANK_W'(b));
    end
  end

  // Explicit ring wrap so non-power-of-two bank counts work
  assign ddr_bank_nxt = (ddr_bank == BANK_W'(NUM_BANKS - 1)) ? '0
                                                              : ddr_bank + BANK_W'(1);

  // Bank rotation, start pulse and sticky error
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      ddr_bank  <= '0;
      lbm_bank  <= '0;
      lbm_start <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      lbm_start <= (state == ST_SWAP);
      if (state == ST_SWAP) begin
        lbm_bank <= ddr_bank;
        ddr_bank <= ddr_bank_nxt;
      end
      if (err_evt) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Per-bank steering; owned banks never coincide while both sides are ready
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      bank_wen  <= '0;
      bank_addr <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_wen[b] <= 1'b0;
        if (ddr_sel[b]) begin
          bank_wen[b]                  <= ddr_we;
          bank_addr[b*ADDR_W +: ADDR_W] <= ddr_addr;
        end else if (lbm_sel[b]) begin
          bank_wen[b]                  <= lbm_we;
          bank_addr[b*ADDR_W +: ADDR_W] <= lbm_addr;
        end
      end
    end
  end

`ifdef PINGPONG_STATS_EN
  // Swap counter, advances on every SWAP->RUN transition and wraps
  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      swap_count <= '0;
    end else if (state == ST_SWAP) begin
      swap_count <= swap_count + CNT_W'(1);
    end
  end
`else
  assign swap_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// Directed bench for bram_pingpong_ctrl: one DUT with two banks, one with three,
// sharing the same stimulus.
module tb_bram_pingpong_ctrl;

  localparam int unsigned AW = 12;

`ifdef PINGPONG_STATS_EN
  localparam logic [15:0] EXP_SWAPS3 = 16'd3;
`else
  localparam logic [15:0] EXP_SWAPS3 = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ddr_req = 0, ddr_we = 0, ddr_chunk_done = 0;
  logic          lbm_req = 0, lbm_we = 0, lbm_chunk_done = 0;
  logic [AW-1:0] ddr_addr = '0, lbm_addr = '0;

  logic          d2_ddr_ready, d2_lbm_ready, d2_lbm_start, d2_proto_err;
  logic [0:0]    d2_ddr_bank, d2_lbm_bank;
  logic [1:0]    d2_bank_wen;
  logic [2*AW-1:0] d2_bank_addr;
  logic [15:0]   d2_swap_count;

  logic          d3_ddr_ready, d3_lbm_ready, d3_lbm_start, d3_proto_err;
  logic [1:0]    d3_ddr_bank, d3_lbm_bank;
  logic [2:0]    d3_bank_wen;
  logic [3*AW-1:0] d3_bank_addr;
  logic [15:0]   d3_swap_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bram_pingpong_ctrl #(.ADDR_W(AW), .NUM_BANKS(2)) u_dut2 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst),
    .ddr_req(ddr_req), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_chunk_done(ddr_chunk_done),
    .lbm_req(lbm_req), .lbm_we(lbm_we), .lbm_addr(lbm_addr), .lbm_chunk_done(lbm_chunk_done),
    .ddr_ready(d2_ddr_ready), .lbm_ready(d2_lbm_ready),
    .ddr_bank(d2_ddr_bank), .lbm_bank(d2_lbm_bank), .lbm_start(d2_lbm_start),
    .bank_wen(d2_bank_wen), .bank_addr(d2_bank_addr),
    .proto_err(d2_proto_err), .swap_count(d2_swap_count)
  );

  bram_pingpong_ctrl #(.ADDR_W(AW), .NUM_BANKS(3)) u_dut3 (
    .m00_axis_aclk(clk), .m00_axis_areset(rst),
    .ddr_req(ddr_req), .ddr_we(ddr_we), .ddr_addr(ddr_addr), .ddr_chunk_done(ddr_chunk_done),
    .lbm_req(lbm_req), .lbm_we(lbm_we), .lbm_addr(lbm_addr), .lbm_chunk_done(lbm_chunk_done),
    .ddr_ready(d3_ddr_ready), .lbm_ready(d3_lbm_ready),
    .ddr_bank(d3_ddr_bank), .lbm_bank(d3_lbm_bank), .lbm_start(d3_lbm_start),
    .bank_wen(d3_bank_wen), .bank_addr(d3_bank_addr),
    .proto_err(d3_proto_err), .swap_count(d3_swap_count)
  );

  // One clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ddr_req = 0; ddr_we = 0; ddr_addr = '0; ddr_chunk_done = 0;
    lbm_req = 0; lbm_we = 0; lbm_addr = '0; lbm_chunk_done = 0;
  endtask

  task automatic test_reset();
    logic [11:0] st;
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    st = {d2_ddr_ready, d2_lbm_ready, d2_ddr_bank, d2_lbm_bank, d2_lbm_start,
          d2_proto_err, d3_ddr_ready, d3_lbm_ready, d3_lbm_start, d3_proto_err,
          d3_ddr_bank == 2'd0, d3_lbm_bank == 2'd0};
    total++;
    if (st !== 12'b10_0_0_0_0_1000_1_1) begin
      bad++; $display("FAIL reset_ctrl: got %b want %b", st, 12'b100000100011);
    end
    total++;
    if ({d2_bank_wen, d3_bank_wen} !== 5'b0 || d2_bank_addr !== '0 || d3_bank_addr !== '0) begin
      bad++; $display("FAIL reset_bank: wen %b/%b addr %h/%h want 0", d2_bank_wen, d3_bank_wen, d2_bank_addr, d3_bank_addr);
    end
    total++;
    if (d2_swap_count !== 16'd0 || d3_swap_count !== 16'd0) begin
      bad++; $display("FAIL reset_swaps: got %0d/%0d want 0", d2_swap_count, d3_swap_count);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_fill_access();
    ddr_req = 1; ddr_we = 1; ddr_addr = 12'h005;
    step();
    ddr_req = 0; ddr_we = 0;
    total++;
    if (d2_bank_wen !== 2'b01 || d2_bank_addr[11:0] !== 12'h005) begin
      bad++; $display("FAIL fill_write2: wen %b addr0 %h want 01 005", d2_bank_wen, d2_bank_addr[11:0]);
    end
    total++;
    if (d3_bank_wen !== 3'b001 || d3_bank_addr !== 36'h000_000_005) begin
      bad++; $display("FAIL fill_write3: wen %b addr %h want 001 000000005", d3_bank_wen, d3_bank_addr);
    end
    total++;
    if (d2_lbm_ready !== 1'b0 || d2_ddr_ready !== 1'b1) begin
      bad++; $display("FAIL fill_ready: ddr %b lbm %b want 1 0", d2_ddr_ready, d2_lbm_ready);
    end
    step();
    total++;
    if (d2_bank_wen !== 2'b00 || d2_bank_addr !== 24'h000_005) begin
      bad++; $display("FAIL fill_idle: wen %b addr %h want 00 000005", d2_bank_wen, d2_bank_addr);
    end
    ddr_req = 1; ddr_we = 0; ddr_addr = 12'h0AB;
    step();
    ddr_req = 0; ddr_addr = '0;
    total++;
    if (d2_bank_wen !== 2'b00 || d2_bank_addr !== 24'h000_0AB) begin
      bad++; $display("FAIL fill_read: wen %b addr %h want 00 0000ab", d2_bank_wen, d2_bank_addr);
    end
  endtask

  task automatic test_fill_swap();
    ddr_chunk_done = 1;
    step();
    ddr_chunk_done = 0;
    total++;
    if ({d2_ddr_ready, d2_lbm_ready, d3_ddr_ready, d3_lbm_ready, d2_lbm_start} !== 5'b0) begin
      bad++; $display("FAIL swap_ready: rdy %b%b/%b%b start %b want all 0",
                      d2_ddr_ready, d2_lbm_ready, d3_ddr_ready, d3_lbm_ready, d2_lbm_start);
    end
    step();
    total++;
    if (d2_lbm_bank !== 1'b0 || d2_ddr_bank !== 1'b1 || d3_lbm_bank !== 2'd0 || d3_ddr_bank !== 2'd1) begin
      bad++; $display("FAIL swap1_banks: d2 ddr %0d lbm %0d d3 ddr %0d lbm %0d want 1 0 1 0",
                      d2_ddr_bank, d2_lbm_bank, d3_ddr_bank, d3_lbm_bank);
    end
    total++;
    if (d2_lbm_start !== 1'b1 || d3_lbm_start !== 1'b1 || d2_ddr_ready !== 1'b1 || d2_lbm_ready !== 1'b1) begin
      bad++; $display("FAIL swap1_run: start %b/%b rdy %b%b want 1/1 11",
                      d2_lbm_start, d3_lbm_start, d2_ddr_ready, d2_lbm_ready);
    end
    step();
    total++;
    if (d2_lbm_start !== 1'b0 || d3_lbm_start !== 1'b0) begin
      bad++; $display("FAIL start_pulse: got %b/%b want 0", d2_lbm_start, d3_lbm_start);
    end
  endtask

  // RUN: d2 ddr=1 lbm=0, d3 ddr=1 lbm=0
  task automatic test_run_steer();
    ddr_req = 1; ddr_we = 1; ddr_addr = 12'h111;
    lbm_req = 1; lbm_we = 1; lbm_addr = 12'h222;
    step();
    clear_inputs();
    total++;
    if (d2_bank_wen !== 2'b11 || d2_bank_addr !== 24'h111_222) begin
      bad++; $display("FAIL run_both2: wen %b addr %h want 11 111222", d2_bank_wen, d2_bank_addr);
    end
    total++;
    if (d3_bank_wen !== 3'b011 || d3_bank_addr !== 36'h000_111_222) begin
      bad++; $display("FAIL run_both3: wen %b addr %h want 011 000111222", d3_bank_wen, d3_bank_addr);
    end
    lbm_req = 1; lbm_we = 0; lbm_addr = 12'h333;
    step();
    clear_inputs();
    total++;
    if (d2_bank_wen !== 2'b00 || d2_bank_addr !== 24'h111_333) begin
      bad++; $display("FAIL run_lbm_read: wen %b addr %h want 00 111333", d2_bank_wen, d2_bank_addr);
    end
    total++;
    if (d2_proto_err !== 1'b0 || d3_proto_err !== 1'b0) begin
      bad++; $display("FAIL run_no_err: got %b/%b want 0", d2_proto_err, d3_proto_err);
    end
  endtask

  task automatic test_both_done();
    ddr_chunk_done = 1; lbm_chunk_done = 1;
    step();
    clear_inputs();
    // A WAIT state would leave one side ready
    total++;
    if ({d2_ddr_ready, d2_lbm_ready, d3_ddr_ready, d3_lbm_ready} !== 4'b0000) begin
      bad++; $display("FAIL both_swap: rdy %b%b/%b%b want 0000", d2_ddr_ready, d2_lbm_ready, d3_ddr_ready, d3_lbm_ready);
    end
    step();
    total++;
    if (d2_ddr_bank !== 1'b0 || d2_lbm_bank !== 1'b1 || d3_ddr_bank !== 2'd2 || d3_lbm_bank !== 2'd1) begin
      bad++; $display("FAIL swap2_banks: d2 ddr %0d lbm %0d d3 ddr %0d lbm %0d want 0 1 2 1",
                      d2_ddr_bank, d2_lbm_bank, d3_ddr_bank, d3_lbm_bank);
    end
    total++;
    if (d3_lbm_start !== 1'b1 || d3_ddr_ready !== 1'b1 || d3_lbm_ready !== 1'b1) begin
      bad++; $display("FAIL swap2_run: start %b rdy %b%b want 1 11", d3_lbm_start, d3_ddr_ready, d3_lbm_ready);
    end
    step();
  endtask

  task automatic test_wait_lbm();
    ddr_chunk_done = 1;
    step();
    clear_inputs();
    total++;
    if (d3_ddr_ready !== 1'b0 || d3_lbm_ready !== 1'b1) begin
      bad++; $display("FAIL wait_lbm_ready: rdy %b%b want 01", d3_ddr_ready, d3_lbm_ready);
    end
    step();
    total++;
    if (d3_ddr_ready !== 1'b0 || d3_lbm_ready !== 1'b1 || d3_lbm_start !== 1'b0) begin
      bad++; $display("FAIL wait_lbm_hold: rdy %b%b start %b want 01 0", d3_ddr_ready, d3_lbm_ready, d3_lbm_start);
    end
    lbm_chunk_done = 1;
    step();
    clear_inputs();
    step();
    total++;
    if (d3_ddr_bank !== 2'd0 || d3_lbm_bank !== 2'd2 || d2_ddr_bank !== 1'b1 || d2_lbm_bank !== 1'b0) begin
      bad++; $display("FAIL swap3_banks: d3 ddr %0d lbm %0d d2 ddr %0d lbm %0d want 0 2 1 0",
                      d3_ddr_bank, d3_lbm_bank, d2_ddr_bank, d2_lbm_bank);
    end
    total++;
    if (d3_swap_count !== EXP_SWAPS3 || d2_swap_count !== EXP_SWAPS3) begin
      bad++; $display("FAIL swap_count: got %0d/%0d want %0d", d3_swap_count, d2_swap_count, EXP_SWAPS3);
    end
    total++;
    if (d3_lbm_start !== 1'b1) begin
      bad++; $display("FAIL swap3_start: got %b want 1", d3_lbm_start);
    end
    step();
  endtask

  task automatic test_reset_mid();
    lbm_chunk_done = 1;
    step();
    clear_inputs();
    total++;
    if (d3_ddr_ready !== 1'b1 || d3_lbm_ready !== 1'b0) begin
      bad++; $display("FAIL wait_ddr_ready: rdy %b%b want 10", d3_ddr_ready, d3_lbm_ready);
    end
    ddr_req = 1; ddr_we = 1; ddr_addr = 12'h4CD;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (d3_ddr_bank !== 2'd0 || d3_lbm_bank !== 2'd0 || d3_bank_wen !== 3'b0 || d3_bank_addr !== '0 ||
        d3_lbm_start !== 1'b0 || d3_proto_err !== 1'b0 || d3_swap_count !== 16'd0) begin
      bad++; $display("FAIL async_reset3: ddr %0d lbm %0d wen %b addr %h cnt %0d want all 0",
                      d3_ddr_bank, d3_lbm_bank, d3_bank_wen, d3_bank_addr, d3_swap_count);
    end
    total++;
    if (d3_ddr_ready !== 1'b1 || d3_lbm_ready !== 1'b0 || d2_ddr_ready !== 1'b1 || d2_lbm_ready !== 1'b0 ||
        d2_bank_addr !== '0 || d2_ddr_bank !== 1'b0) begin
      bad++; $display("FAIL async_reset_fill: rdy %b%b/%b%b want 10/10", d3_ddr_ready, d3_lbm_ready, d2_ddr_ready, d2_lbm_ready);
    end
    clear_inputs();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_proto_err();
    lbm_req = 1; lbm_we = 1; lbm_addr = 12'h077;
    step();
    clear_inputs();
    total++;
    if (d2_bank_wen !== 2'b00 || d3_bank_wen !== 3'b000 || d3_bank_addr !== '0) begin
      bad++; $display("FAIL drop_req: wen %b/%b addr %h want 0", d2_bank_wen, d3_bank_wen, d3_bank_addr);
    end
    total++;
    if (d2_proto_err !== 1'b1 || d3_proto_err !== 1'b1) begin
      bad++; $display("FAIL err_set: got %b/%b want 1", d2_proto_err, d3_proto_err);
    end
    lbm_chunk_done = 1;
    step();
    clear_inputs();
    step();
    step();
    total++;
    if (d3_ddr_ready !== 1'b1 || d3_lbm_ready !== 1'b0 || d3_lbm_start !== 1'b0 || d3_ddr_bank !== 2'd0) begin
      bad++; $display("FAIL ignore_done: rdy %b%b start %b ddr %0d want 10 0 0",
                      d3_ddr_ready, d3_lbm_ready, d3_lbm_start, d3_ddr_bank);
    end
    total++;
    if (d2_proto_err !== 1'b1 || d3_proto_err !== 1'b1) begin
      bad++; $display("FAIL err_sticky: got %b/%b want 1", d2_proto_err, d3_proto_err);
    end
    rst = 1'b1;
    #1;
    total++;
    if (d2_proto_err !== 1'b0 || d3_proto_err !== 1'b0) begin
      bad++; $display("FAIL err_clear: got %b/%b want 0", d2_proto_err, d3_proto_err);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_access();
    test_fill_swap();
    test_run_steer();
    test_both_done();
    test_wait_lbm();
    test_reset_mid();
    test_proto_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
